// File: rtl/nios2system_multitimer.sv
// Multi-channel down-counting interval timer with per-channel prescaler, snapshot register
// and timeout interrupt, exposed through a chip-select register bus with registered read data.
module nios2system_multitimer #(
    parameter int unsigned      NUM_CH       = 2,
    parameter int unsigned      CNT_W        = 32,
    parameter int unsigned      PRE_W        = 8,
    parameter logic [CNT_W-1:0] PERIOD_RESET = 49999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);
    localparam logic [2:0] RegStatus   = 3'd0;
    localparam logic [2:0] RegControl  = 3'd1;
    localparam logic [2:0] RegPeriod   = 3'd2;
    localparam logic [2:0] RegSnap     = 3'd3;
    localparam logic [2:0] RegPrescale = 3'd4;
    localparam logic [2:0] RegIrqStat  = 3'd5;

    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [CNT_W-1:0]  snap_q   [NUM_CH];
    logic [CNT_W-1:0]  snap_d   [NUM_CH];
    logic [PRE_W-1:0]  pre_q    [NUM_CH];
    logic [PRE_W-1:0]  pre_d    [NUM_CH];
    logic [PRE_W-1:0]  pcnt_q   [NUM_CH];
    logic [PRE_W-1:0]  pcnt_d   [NUM_CH];
    logic [NUM_CH-1:0] run_q, run_d, to_q, to_d, ito_q, ito_d, cont_q, cont_d;
    logic [NUM_CH-1:0] tick, term, sel, irq_vec;
    logic [31:0]       rdata_q, rdata_d;
    logic              wr_en;
    logic [1:0]        ch_sel;
    logic [2:0]        reg_sel;

    assign wr_en    = chipselect & ~write_n;
    assign ch_sel   = address[4:3];
    assign reg_sel  = address[2:0];
    assign irq_vec  = to_q & ito_q;
    assign irq      = |irq_vec;
    assign readdata = rdata_q;

    always_comb begin
        run_d  = run_q;
        to_d   = to_q;
        ito_d  = ito_q;
        cont_d = cont_q;
        tick   = '0;
        term   = '0;
        sel    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c]    = cnt_q[c];
            period_d[c] = period_q[c];
            snap_d[c]   = snap_q[c];
            pre_d[c]    = pre_q[c];
            sel[c]      = wr_en && (int'(ch_sel) == c);
            // >= rather than == so lowering PRESCALE mid-count cannot strand the divider
            tick[c]     = run_q[c] && (pcnt_q[c] >= pre_q[c]);
            term[c]     = tick[c] && (cnt_q[c] == '0);
            if (!run_q[c] || tick[c]) begin
                pcnt_d[c] = '0;
            end else begin
                pcnt_d[c] = pcnt_q[c] + PRE_W'(1);
            end
            if (term[c]) begin
                cnt_d[c] = period_q[c];
                to_d[c]  = 1'b1;
                if (!cont_q[c]) run_d[c] = 1'b0;
            end else if (tick[c]) begin
                cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end
            if (sel[c]) begin
                case (reg_sel)
                    RegStatus: if (!term[c]) to_d[c] = 1'b0;
                    RegControl: begin
                        ito_d[c]  = writedata[0];
                        cont_d[c] = writedata[1];
                        if (writedata[2]) begin
                            run_d[c]  = 1'b1;
                            pcnt_d[c] = '0;
                        end else if (writedata[3]) begin
                            run_d[c] = 1'b0;
                        end
                    end
                    RegPeriod: begin
                        period_d[c] = writedata[CNT_W-1:0];
                        cnt_d[c]    = writedata[CNT_W-1:0];
                        run_d[c]    = 1'b0;
                        pcnt_d[c]   = '0;
                    end
                    RegSnap:     snap_d[c] = cnt_q[c];
                    RegPrescale: pre_d[c]  = writedata[PRE_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(ch_sel) == c) begin
                case (reg_sel)
                    RegStatus:   rdata_d = {30'b0, run_q[c], to_q[c]};
                    RegControl:  rdata_d = {30'b0, cont_q[c], ito_q[c]};
                    RegPeriod:   rdata_d = 32'(period_q[c]);
                    RegSnap:     rdata_d = 32'(snap_q[c]);
                    RegPrescale: rdata_d = 32'(pre_q[c]);
                    RegIrqStat:  rdata_d = 32'(irq_vec);
                    default:     rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q   <= '0;
            to_q    <= '0;
            ito_q   <= '0;
            cont_q  <= '0;
            rdata_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c]    <= PERIOD_RESET;
                period_q[c] <= PERIOD_RESET;
                snap_q[c]   <= '0;
                pre_q[c]    <= '0;
                pcnt_q[c]   <= '0;
            end
        end else begin
            run_q   <= run_d;
            to_q    <= to_d;
            ito_q   <= ito_d;
            cont_q  <= cont_d;
            rdata_q <= rdata_d;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c]    <= cnt_d[c];
                period_q[c] <= period_d[c];
                snap_q[c]   <= snap_d[c];
                pre_q[c]    <= pre_d[c];
                pcnt_q[c]   <= pcnt_d[c];
            end
        end
    end
endmodule

// File: tb/tb_nios2system_multitimer.sv
// Scoreboarded bench for nios2system_multitimer: reads push expected data, a monitor pops
// and compares one cycle later when the registered read data is presented.
module tb_nios2system_multitimer;
    localparam int ST = 0, CTL = 1, PER = 2, SNP = 3, PRE = 4, IRQ = 5;

    logic        clk;
    logic        reset_n;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    logic        rd_en;
    logic        rd_pend;
    int          checks;
    int          failures;
    string       name_q[$];
    logic [31:0] data_q[$];

    nios2system_multitimer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial rd_pend = 1'b0;
    always @(posedge clk) rd_pend <= rd_en;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_pend) begin
            if (name_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read actual=0x%0h expected=none", readdata);
            end else begin
                chk(name_q.pop_front(), readdata, data_q.pop_front());
            end
        end
    end

    function automatic logic [4:0] A(input int ch, input int r);
        return 5'(ch * 8 + r);
    endfunction

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d; rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_cs(input logic [4:0] a, input logic [31:0] e, input string n,
                         input logic cs);
        chipselect = cs; write_n = 1'b1; address = a; rd_en = 1'b1;
        name_q.push_back(n);
        data_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
        rd_cs(a, e, n, 1'b1);
    endtask

    task automatic idle();
        chipselect = 1'b0; write_n = 1'b1; rd_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        rd_en = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle();

        rd(A(0, ST), 0, "rst_status");
        rd(A(0, PER), 49999, "rst_period");
        rd(A(1, PRE), 0, "rst_prescale");
        rd(A(0, CTL), 0, "rst_control");
        rd(A(0, SNP), 0, "rst_snap");
        wr(A(0, SNP), 0);
        rd(A(0, SNP), 49999, "rst_counter");

        // One-shot: terminal tick 4 clocks after START
        wr(A(0, PER), 3); wr(A(0, PRE), 0); wr(A(0, CTL), 32'h5);
        for (int k = 0; k < 4; k++) rd(A(0, ST), 2, "oneshot_running");
        rd(A(0, ST), 1, "oneshot_timeout");
        chk("oneshot_irq", 32'(irq), 32'h1);
        rd(A(0, IRQ), 1, "irqstat_ch0");
        wr(A(0, SNP), 0);
        rd(A(0, SNP), 3, "oneshot_reload");
        wr(A(0, ST), 0);
        chk("status_clear_irq", 32'(irq), 32'h0);
        rd(A(0, ST), 0, "status_clear");

        // Continuous with prescale: TO every 6 clocks
        wr(A(1, PER), 2); wr(A(1, PRE), 1); wr(A(1, CTL), 32'h7);
        for (int k = 0; k < 6; k++) rd(A(1, ST), 2, "cont_running");
        rd(A(1, ST), 3, "cont_timeout1");
        wr(A(1, ST), 0);
        for (int k = 0; k < 4; k++) rd(A(1, ST), 2, "cont_cleared");
        rd(A(0, IRQ), 2, "irqstat_ch1");
        rd(A(1, ST), 3, "cont_timeout2");
        wr(A(1, ST), 0);
        rd(A(1, ST), 2, "cont_cleared2");
        rd(A(1, ST), 2, "cont_cleared3");
        wr(A(1, ST), 0);
        rd(A(1, ST), 3, "status_write_on_terminal");
        wr(A(1, CTL), 32'h8);
        rd(A(1, ST), 1, "cont_stopped");
        wr(A(1, ST), 0);
        rd(A(1, ST), 0, "cont_cleared_final");

        // PERIOD write while running
        wr(A(0, PER), 20); wr(A(0, CTL), 32'h6);
        rd(A(0, ST), 2, "run_before_period");
        wr(A(0, PER), 10);
        rd(A(0, ST), 0, "period_write_stops");
        wr(A(0, SNP), 0);
        rd(A(0, SNP), 10, "period_write_reload");
        rd(A(0, PER), 10, "period_value");

        // Snapshot captures the pre-update counter
        wr(A(0, CTL), 32'h4);
        wr(A(0, SNP), 0);
        rd(A(0, SNP), 10, "snap_pre_update1");
        wr(A(0, SNP), 0);
        rd(A(0, SNP), 8, "snap_pre_update2");
        wr(A(0, CTL), 32'h8);

        wr(A(0, CTL), 32'hC);
        rd(A(0, ST), 2, "start_wins");
        wr(A(0, CTL), 32'h8);
        rd(A(0, ST), 0, "stop");

        // Address decode
        rd(A(0, 6), 0, "rsvd6");
        rd(A(1, 7), 0, "rsvd7");
        rd(A(3, PER), 0, "ch3_period");
        rd(A(2, ST), 0, "ch2_status");
        wr(A(3, PER), 5); wr(A(2, CTL), 32'h5); wr(A(0, 6), 32'hFFFF_FFFF);
        wr(A(1, 7), 32'hFFFF_FFFF); wr(A(1, IRQ), 32'hFFFF_FFFF);
        rd(A(1, PER), 2, "ch1_period_kept");
        rd(A(0, PER), 10, "ch0_period_kept");
        rd(A(0, ST), 0, "ch0_not_started");
        rd(A(1, CTL), 0, "ch1_ctrl_kept");
        rd_cs(A(0, PER), 10, "read_without_cs", 1'b0);

        // Reset mid-count
        wr(A(1, PRE), 0); wr(A(1, PER), 0); wr(A(1, CTL), 32'h5);
        idle();
        chk("irq_before_reset", 32'(irq), 32'h1);
        wr(A(0, PER), 5); wr(A(0, CTL), 32'h7);
        rd(A(0, PER), 5, "period_before_reset");
        chipselect = 1'b0; write_n = 1'b1; rd_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midcount_reset_readdata", readdata, 32'h0);
        chk("midcount_reset_irq", 32'(irq), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle();
        rd(A(0, ST), 0, "post_rst_status0");
        rd(A(1, ST), 0, "post_rst_status1");
        rd(A(0, CTL), 0, "post_rst_control");
        rd(A(0, PER), 49999, "post_rst_period");
        wr(A(0, SNP), 0);
        rd(A(0, SNP), 49999, "post_rst_counter");
        chk("post_rst_irq", 32'(irq), 32'h0);
        repeat (5) idle();
        rd(A(0, ST), 0, "no_autostart");
        wr(A(0, SNP), 0);
        rd(A(0, SNP), 49999, "counter_held");

        repeat (3) idle();
        if (name_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", name_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nios2system_multitimer.md
NIOS2SYSTEM_MULTITIMER -- requirements
Module: nios2system_multitimer

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent timer channels (1-4).
REQ-002 Parameter CNT_W, default 32, counter and period width in bits (8-32).
REQ-003 Parameter PRE_W, default 8, prescaler width in bits (1-16).
REQ-004 Parameter PERIOD_RESET, default 49999, reset value of every channel's period and counter.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 address  input  5  bits[4:3] select the channel, bits[2:0] select the register.
REQ-009 chipselect  input  1  slave select.
REQ-010 write_n  input  1  active-low write; a write occurs when chipselect=1 and write_n=0.
REQ-011 writedata  input  32  write data.
REQ-012 readdata  output  32  registered read data.
REQ-013 irq  output  1  OR of all channel interrupt requests.

Function
REQ-014 Per-channel register map: 0 STATUS, 1 CONTROL, 2 PERIOD, 3 SNAP, 4 PRESCALE, 5 IRQSTAT, 6-7 reserved.
- Reserved registers read 0.
- Writes to reserved registers are ignored.
- Channel indices >= NUM_CH read 0; writes to them are ignored.
REQ-015 STATUS SHALL read {30'b0, RUN, TO}; any write to it clears TO.
REQ-016 CONTROL bits SHALL be: [0] ITO (interrupt enable), [1] CONT (continuous), [2] START, [3] STOP.
- Bits [1:0] are stored; [3:2] are write strobes only.
- Reads return {28'b0, 2'b00, CONT, ITO}.
REQ-017 PERIOD SHALL hold CNT_W bits. Writes take writedata[CNT_W-1:0]. Reads are zero-extended.
REQ-018 Any write to SNAP SHALL copy the live counter into the snapshot register; reads return the snapshot, zero-extended.
REQ-019 PRESCALE SHALL hold PRE_W bits (value P). A channel tick occurs once every P+1 clocks while RUN=1; P=0 gives a tick every clock.
REQ-020 The prescaler count SHALL reset to 0 on START, on period reload, and whenever RUN=0.
REQ-021 IRQSTAT, at any channel address, SHALL read the per-channel TO&ITO vector in bits[NUM_CH-1:0]; writes to it are ignored.
REQ-022 readdata SHALL be registered: the value appears the cycle after address is presented, and is updated every cycle regardless of chipselect.
REQ-023 Channel states are STOPPED (RUN=0) and RUNNING (RUN=1).
- STOPPED -> RUNNING on a CONTROL write with START=1.
- RUNNING -> STOPPED on any of: a CONTROL write with STOP=1; a PERIOD write; a terminal tick with CONT=0.
- START and STOP in the same write: START wins.
REQ-024 On a tick in RUNNING, the counter SHALL decrement by 1 if nonzero.
REQ-025 A tick while the counter is 0 is a terminal tick, with these effects in the same cycle:
- the counter reloads from PERIOD;
- TO is set;
- the channel stops if CONT=0.
REQ-026 A PERIOD write SHALL reload the counter from the new PERIOD value in the following cycle.
REQ-027 When a STATUS write and a terminal tick coincide, TO SHALL remain 1 (the set wins).
REQ-028 When a SNAP write and a counter update coincide, the snapshot SHALL capture the pre-update value.
REQ-029 Counter arithmetic SHALL be CNT_W bits with no wrap below 0. A PERIOD of 0 gives a terminal tick on every tick.
REQ-030 Channels SHALL be fully independent; there is no shared prescaler.
REQ-031 irq SHALL be combinational from registered TO and ITO, asserted while any channel has TO=1 and ITO=1.

Reset
REQ-032 While reset_n=0 the block SHALL apply these values, independent of clk:
- counters and PERIOD = PERIOD_RESET;
- PRESCALE = 0, snapshot = 0;
- RUN = 0, TO = 0, ITO = 0, CONT = 0;
- readdata = 0, irq = 0.
REQ-033 Reset asserted mid-count SHALL abort the count with no pending timeout; after release, a channel runs only after a new START.

Verification
REQ-034 One-shot: ch0 PERIOD=3, PRESCALE=0, CONTROL=0x5 -> terminal tick 4 clocks after START takes effect; TO=1, RUN=0, irq=1; STATUS write -> irq=0.
REQ-035 Continuous with prescale: ch1 PERIOD=2, PRESCALE=1, CONTROL=0x7 -> TO sets every 6 clocks; IRQSTAT reads 0x2; RUN stays 1.
REQ-036 PERIOD write while running: ch0 running, write PERIOD=10 -> RUN=0 and counter=10 the next cycle; SNAP write then SNAP read returns 10.
REQ-037 Simultaneous events:
- STATUS write on the terminal-tick cycle -> TO reads 1.
- CONTROL write 0xC -> RUN=1.
REQ-038 Reset mid-count: assert reset_n=0 with counter=5 -> all reset values (counter=49999, readdata=0, irq=0) are present before the next clk edge.
REQ-039 Address decode: reads of reserved registers and of channel 3 (NUM_CH=2) return 0 with 1-cycle latency; writes to them change no state.
